// File: rtl/lectura_rafaga.sv
// Burst read sequencer: walks `longitud` addresses from `dir`, one read per acknowledge.
// Optional wait-timeout guarded by macro LECTURA_TIMEOUT_EN (disabled by default).
module lectura_rafaga #(
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar_i,
  input  logic [ADDR_W-1:0] dir_i,
  input  logic [LEN_W-1:0]  longitud_i,
  input  logic              listo_i,
  output logic [ADDR_W-1:0] dir_out_o,
  output logic              activa_o,
  output logic              final_o,
  output logic [LEN_W-1:0]  leidas_o,
  output logic              error_o
);

  typedef enum logic [1:0] {INICIO, LEE, FINALIZAR} estado_t;

  estado_t           estado_q;
  logic [ADDR_W-1:0] dir_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  leidas_q;
  logic              activa_q;
  logic              final_q;
  logic [LEN_W-1:0]  leidas_d;
  logic              vencido;

  assign leidas_d = leidas_q + LEN_W'(1);

`ifdef LECTURA_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] espera_q;
  logic             error_q;

  // Reaching TIMEOUT this cycle without listo ends the burst on the next edge.
  assign vencido = (espera_q == CNT_W'(TIMEOUT - 1));
  assign error_o = error_q;
`else
  // No wait counter: a burst ends only by acknowledge, abort or reset.
  assign vencido = (TIMEOUT < 0);
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // Reset and abort share one path; reset thus wins over every other input.
    if (reset || !iniciar_i) begin
      estado_q <= INICIO;
      dir_q    <= '0;
      len_q    <= '0;
      leidas_q <= '0;
      activa_q <= 1'b0;
      final_q  <= 1'b0;
`ifdef LECTURA_TIMEOUT_EN
      espera_q <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      case (estado_q)
        INICIO: begin
          len_q    <= longitud_i;
          leidas_q <= '0;
`ifdef LECTURA_TIMEOUT_EN
          espera_q <= '0;
          error_q  <= 1'b0;
`endif
          if (longitud_i != '0) begin
            estado_q <= LEE;
            dir_q    <= dir_i;
            activa_q <= 1'b1;
          end else begin
            estado_q <= FINALIZAR;
            final_q  <= 1'b1;
          end
        end

        LEE: begin
          if (listo_i) begin
            leidas_q <= leidas_d;
`ifdef LECTURA_TIMEOUT_EN
            espera_q <= '0;
`endif
            if (leidas_d == len_q) begin
              estado_q <= FINALIZAR;
              dir_q    <= '0;
              activa_q <= 1'b0;
              final_q  <= 1'b1;
            end else begin
              dir_q <= dir_q + ADDR_W'(1);
            end
          end else if (vencido) begin
            estado_q <= FINALIZAR;
            dir_q    <= '0;
            activa_q <= 1'b0;
            final_q  <= 1'b1;
`ifdef LECTURA_TIMEOUT_EN
            error_q  <= 1'b1;
`endif
          end else begin
`ifdef LECTURA_TIMEOUT_EN
            espera_q <= espera_q + CNT_W'(1);
`endif
          end
        end

        FINALIZAR: begin
          // Held until iniciar drops; the abort path returns to INICIO.
          estado_q <= FINALIZAR;
        end

        default: begin
          estado_q <= INICIO;
          dir_q    <= '0;
          leidas_q <= '0;
          activa_q <= 1'b0;
          final_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dir_out_o = dir_q;
  assign activa_o  = activa_q;
  assign final_o   = final_q;
  assign leidas_o  = leidas_q;

endmodule

// File: tb/tb_lectura_rafaga.sv
// Self-checking bench for lectura_rafaga: vector table, corner sequences and random
// stimulus compared every cycle against a transaction-level burst model.
module tb_lectura_rafaga;

  localparam int AW = 8;
  localparam int LW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset, iniciar, listo;
  logic [AW-1:0] dir;
  logic [LW-1:0] longitud;
  logic [AW-1:0] dir_out;
  logic          activa, fin, error;
  logic [LW-1:0] leidas;

  always #5 clk = ~clk;

  lectura_rafaga #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .iniciar_i  (iniciar),
    .dir_i      (dir),
    .longitud_i (longitud),
    .listo_i    (listo),
    .dir_out_o  (dir_out),
    .activa_o   (activa),
    .final_o    (fin),
    .leidas_o   (leidas),
    .error_o    (error)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Burst model: a burst is (base, length, reads done, wait cycles); outputs derive from it.
  bit m_busy, m_done, m_err;
  int m_base, m_len, m_n, m_wait;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (reset || !iniciar) begin
      m_busy = 0; m_done = 0; m_err = 0; m_n = 0; m_wait = 0;
    end else if (!m_busy && !m_done) begin
      m_base = int'(dir); m_len = int'(longitud); m_n = 0; m_wait = 0;
      if (m_len == 0) m_done = 1;
      else            m_busy = 1;
    end else if (m_busy) begin
      if (listo) begin
        m_n++;
        m_wait = 0;
        if (m_n == m_len) begin m_busy = 0; m_done = 1; end
      end else begin
        m_wait++;
`ifdef LECTURA_TIMEOUT_EN
        if (m_wait == TO) begin m_busy = 0; m_done = 1; m_err = 1; end
`endif
      end
    end
  endtask

  task automatic model_check();
    int exp_dir;
    exp_dir = m_busy ? ((m_base + m_n) % (1 << AW)) : 0;
    chk("model_dir_out", int'(dir_out), exp_dir);
    chk("model_activa",  int'(activa),  int'(m_busy));
    chk("model_final",   int'(fin),     int'(m_done));
    chk("model_leidas",  int'(leidas),  (m_busy || m_done) ? m_n : 0);
    chk("model_error",   int'(error),   int'(m_err));
  endtask

  // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
  task automatic cycle(input bit r, input bit ini, input logic [AW-1:0] d,
                       input logic [LW-1:0] l, input bit ls);
    reset = r; iniciar = ini; dir = d; longitud = l; listo = ls;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    model_check();
  endtask

  typedef struct {
    bit            r;
    bit            ini;
    logic [AW-1:0] d;
    logic [LW-1:0] l;
    bit            ls;
    logic [AW-1:0] e_dir;
    bit            e_act;
    bit            e_fin;
    logic [LW-1:0] e_leid;
  } vec_t;

  vec_t tbl[20];
  logic [AW-1:0] wrap_addr[9];

  initial begin
    // Basic burst 0x10 x3, dir/longitud changed mid-burst, hold, release
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h10, 8'd3, 1'b1, 8'h10, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h77, 8'd9, 1'b1, 8'h11, 1'b1, 1'b0, 8'd1};
    tbl[3]  = '{1'b0, 1'b1, 8'h77, 8'd9, 1'b1, 8'h12, 1'b1, 1'b0, 8'd2};
    tbl[4]  = '{1'b0, 1'b1, 8'h77, 8'd9, 1'b1, 8'h00, 1'b0, 1'b1, 8'd3};
    tbl[5]  = '{1'b0, 1'b1, 8'h77, 8'd9, 1'b1, 8'h00, 1'b0, 1'b1, 8'd3};
    tbl[6]  = '{1'b0, 1'b0, 8'h77, 8'd9, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    // Zero length
    tbl[7]  = '{1'b0, 1'b1, 8'h33, 8'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[8]  = '{1'b0, 1'b1, 8'h33, 8'd0, 1'b1, 8'h00, 1'b0, 1'b1, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 8'h33, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    // Abort after 2 of 5, restart from new base
    tbl[10] = '{1'b0, 1'b1, 8'h40, 8'd5, 1'b0, 8'h40, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 1'b1, 8'h40, 8'd5, 1'b1, 8'h41, 1'b1, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b1, 8'h40, 8'd5, 1'b1, 8'h42, 1'b1, 1'b0, 8'd2};
    tbl[13] = '{1'b0, 1'b0, 8'h40, 8'd5, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[14] = '{1'b0, 1'b1, 8'h80, 8'd5, 1'b0, 8'h80, 1'b1, 1'b0, 8'd0};
    // Reset mid-burst with iniciar high, then restart through INICIO
    tbl[15] = '{1'b1, 1'b1, 8'h80, 8'd5, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0};
    tbl[16] = '{1'b0, 1'b1, 8'h20, 8'd2, 1'b1, 8'h20, 1'b1, 1'b0, 8'd0};
    tbl[17] = '{1'b0, 1'b1, 8'h20, 8'd2, 1'b1, 8'h21, 1'b1, 1'b0, 8'd1};
    tbl[18] = '{1'b0, 1'b1, 8'h20, 8'd2, 1'b1, 8'h00, 1'b0, 1'b1, 8'd2};
    tbl[19] = '{1'b0, 1'b0, 8'h20, 8'd2, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};

    wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFE; wrap_addr[2] = 8'hFE;
    wrap_addr[3] = 8'hFF; wrap_addr[4] = 8'hFF; wrap_addr[5] = 8'hFF;
    wrap_addr[6] = 8'h00; wrap_addr[7] = 8'h00; wrap_addr[8] = 8'h00;

    reset = 1'b1; iniciar = 1'b0; dir = '0; longitud = '0; listo = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].r, tbl[i].ini, tbl[i].d, tbl[i].l, tbl[i].ls);
      chk("tbl_dir_out", int'(dir_out), int'(tbl[i].e_dir));
      chk("tbl_activa",  int'(activa),  int'(tbl[i].e_act));
      chk("tbl_final",   int'(fin),     int'(tbl[i].e_fin));
      chk("tbl_leidas",  int'(leidas),  int'(tbl[i].e_leid));
      chk("tbl_error",   int'(error),   0);
      $display("vec %0d: rst=%0b ini=%0b dir=%02h len=%0d listo=%0b -> dir_out=%02h activa=%0b final=%0b leidas=%0d",
               i, tbl[i].r, tbl[i].ini, tbl[i].d, tbl[i].l, tbl[i].ls, dir_out, activa, fin, leidas);
    end

    // Wrap and stall: 0xFE x3, acknowledge every third cycle
    cycle(1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    cycle(1'b0, 1'b1, 8'hFE, 8'd3, 1'b0);
    for (int k = 0; k < 9; k++) begin
      chk("wrap_dir_out", int'(dir_out), int'(wrap_addr[k]));
      chk("wrap_activa",  int'(activa),  1);
      cycle(1'b0, 1'b1, 8'h00, 8'd0, (k % 3) == 2);
    end
    chk("wrap_final",  int'(fin),    1);
    chk("wrap_leidas", int'(leidas), 3);
    $display("wrap/stall burst: final=%0b leidas=%0d", fin, leidas);

    // Target never acknowledges
    cycle(1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    cycle(1'b0, 1'b1, 8'h55, 8'd2, 1'b0);
`ifdef LECTURA_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) begin
      chk("to_wait_activa", int'(activa), 1);
      cycle(1'b0, 1'b1, 8'h00, 8'd0, 1'b0);
    end
    chk("to_wait_activa", int'(activa), 1);
    cycle(1'b0, 1'b1, 8'h00, 8'd0, 1'b0);
    chk("to_final",  int'(fin),    1);
    chk("to_error",  int'(error),  1);
    chk("to_leidas", int'(leidas), 0);
    cycle(1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    chk("to_error_clear", int'(error), 0);
`else
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, 8'h00, 8'd0, 1'b0);
    chk("nack_activa",  int'(activa),  1);
    chk("nack_dir_out", int'(dir_out), 8'h55);
    chk("nack_final",   int'(fin),     0);
`endif
    $display("no-ack burst: activa=%0b final=%0b error=%0b", activa, fin, error);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 19) != 0),
            AW'($urandom), LW'($urandom_range(0, 6)), $urandom_range(0, 1) == 1);
    end
    $display("random traffic: 3000 cycles");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
